multi_clk_divider: RTL and testbench
====================================

Name: multi_clk_divider

Overview:
- Parametrised, multi-channel successor to the single-output programmable clock divider.
- Generates NCH independent divided clock/PWM-style outputs from clk_in, each with its own:
  - programmable period and high time (duty),
  - phase offset,
  - per-channel enable.
- Divisor updates are double-buffered and applied only at period boundaries, so outputs never glitch.
- A common sync input re-aligns all channels. Drives carrier/timebase clocks for the PWM modulators.

Parameters:
- NCH, 4, number of output channels (1..16)
- W, 16, counter/divisor width in bits (2..32)

Ports:
- clk_in  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- en  input  NCH  per-channel run enable, level sensitive
- div  input  NCH*W  period in clk_in cycles; channel i at bits [i*W +: W]
- high  input  NCH*W  high time in cycles, same packing
- phase  input  NCH*W  counter start value after enable/sync, same packing
- load  input  NCH  one-cycle strobe: capture div/high/phase of channel i into its shadow registers
- sync  input  1  one-cycle strobe: restart all enabled channels at their phase
- clk_out  output  NCH  divided clock, registered
- tick  output  NCH  one-cycle pulse at each period wrap, registered
- pending  output  NCH  shadow values captured but not yet active

Behaviour:
- Reset (rst=1, synchronous, highest priority):
  - cnt, div_a, high_a, phase_a and shadow registers all cleared to 0.
  - clk_out=0, tick=0, pending=0.
  - Channels are stopped (div_a=0) until their first load.
- Per channel, running = en[i] && div_a>=1.
- Counter: cnt ranges 0..div_a-1. wrap = running && cnt==div_a-1. Each cycle:
  - if wrap, cnt_next=0;
  - else if running, cnt_next=cnt+1;
  - else cnt_next=0.
- Outputs, registered from next-state values (same-cycle alignment with cnt):
  - clk_out <= running && (cnt_next < high_a).
  - tick <= wrap. tick is high in the cycle where cnt==0 after a wrap, and is never asserted when not running.
- Duty rules:
  - high_a=0 gives constant 0.
  - high_a>=div_a gives constant 1.
  - div_a=1 gives cnt stuck at 0, tick every cycle, and clk_out=(high_a!=0).
  - div_a=0 stops the channel: clk_out=0, tick=0.
- Shadow update:
  - load[i] copies the inputs into the shadow registers and sets pending[i].
  - A later load before the update overwrites the shadows (last write wins).
  - The shadows are transferred into div_a/high_a/phase_a and pending cleared on any of:
    - wrap,
    - the cycle the channel is not running,
    - sync.
  - load coincident with wrap or sync: the input values are used directly in that same transfer, and pending ends 0.
- Phase:
  - Effective start value is ph = (phase_a < div_a) ? phase_a : 0, using the values active after any transfer that cycle.
  - On an en[i] 0->1 edge, or on sync with en[i]=1, cnt_next=ph instead of the normal next value.
  - clk_out and tick follow from that cnt_next. tick is not asserted for a sync/enable restart.
- Priority: rst > sync > enable edge > wrap > count.
- en low: cnt forced to 0 and outputs 0 next cycle. Shadows and pending keep working.
- Reset mid-period: outputs are 0 the cycle after the rst edge. There is no partial pulse after rst deasserts, because the channel stays stopped until a load.
- All arithmetic is unsigned W-bit. cnt+1 never overflows, because cnt<div_a<=2^W-1.

Test Plan:
- Basic divide: ch0 load div=4, high=2, phase=0, en=1 -> clk_out 1,1,0,0 repeating; tick every 4th cycle coincident with cnt=0.
- Glitch-free update: running at div=4, high=2; load div=6, high=3 at cnt=1 -> pending=1; current period completes as 1100; next period is 111000; pending clears at wrap.
- Phase/sync: ch0 phase=0, ch1 phase=2, both div=4, high=2, then pulse sync -> ch1 clk_out leads ch0 by 2 cycles; no tick on the sync cycle; phase=5 with div=4 behaves as phase 0.
- Boundaries:
  - high=0 -> constant 0.
  - high=4, div=4 -> constant 1, tick every 4.
  - div=1, high=1 -> clk_out=1, tick every cycle.
  - div=0 -> all zero.
- Simultaneity: load coincident with wrap applies the new div immediately (pending stays 0); load and sync together restart at the new phase.
- Reset mid-operation: assert rst at cnt=2 on all channels -> next cycle clk_out=0, tick=0, pending=0; after release, outputs stay 0 until load+en.

Source files
------------

// File: rtl/multi_clk_divider.sv
// Multi-channel programmable clock divider.
// Each channel produces a divided clock and a wrap tick from clk_in with its
// own period, high time and phase. New settings are captured into shadow
// registers and only become active at a period boundary, while the channel
// is stopped, or on sync, so a running output never glitches mid-period.
module multi_clk_divider #(
    parameter int NCH = 4,
    parameter int W   = 16
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic [NCH-1:0]     en,
    input  logic [NCH*W-1:0]   div,
    input  logic [NCH*W-1:0]   high,
    input  logic [NCH*W-1:0]   phase,
    input  logic [NCH-1:0]     load,
    input  logic               sync,
    output logic [NCH-1:0]     clk_out,
    output logic [NCH-1:0]     tick,
    output logic [NCH-1:0]     pending
);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [W-1:0] div_in;
        logic [W-1:0] high_in;
        logic [W-1:0] phase_in;

        logic [W-1:0] cnt_q,     cnt_d;
        logic [W-1:0] div_a_q,   div_a_d;
        logic [W-1:0] high_a_q,  high_a_d;
        logic [W-1:0] phase_a_q, phase_a_d;
        logic [W-1:0] div_s_q,   div_s_d;
        logic [W-1:0] high_s_q,  high_s_d;
        logic [W-1:0] phase_s_q, phase_s_d;
        logic         pending_q, pending_d;
        logic         en_prev_q, en_prev_d;
        logic         clk_out_q, clk_out_d;
        logic         tick_q,    tick_d;

        logic         running;
        logic         running_n;
        logic         wrap;
        logic         xfer;
        logic         restart;
        logic [W-1:0] ph;

        assign div_in   = div[i*W +: W];
        assign high_in  = high[i*W +: W];
        assign phase_in = phase[i*W +: W];

        // Next-state logic: shadow capture, boundary transfer, counter and outputs.
        // The outputs are derived from the post-transfer settings and next count
        // so that clk_out/tick line up with the registered counter value.
        always_comb begin
            running   = en[i] && (div_a_q != '0);
            wrap      = running && (cnt_q == div_a_q - W'(1));
            xfer      = wrap || !running || sync;

            div_s_d   = load[i] ? div_in   : div_s_q;
            high_s_d  = load[i] ? high_in  : high_s_q;
            phase_s_d = load[i] ? phase_in : phase_s_q;

            div_a_d   = div_a_q;
            high_a_d  = high_a_q;
            phase_a_d = phase_a_q;
            pending_d = pending_q | load[i];
            if (xfer) begin
                div_a_d   = load[i] ? div_in   : div_s_q;
                high_a_d  = load[i] ? high_in  : high_s_q;
                phase_a_d = load[i] ? phase_in : phase_s_q;
                pending_d = 1'b0;
            end

            running_n = en[i] && (div_a_d != '0);
            ph        = (phase_a_d < div_a_d) ? phase_a_d : '0;
            restart   = en[i] && (sync || !en_prev_q);

            if (restart) begin
                cnt_d = ph;
            end else if (wrap) begin
                cnt_d = '0;
            end else if (running) begin
                cnt_d = cnt_q + W'(1);
            end else begin
                cnt_d = '0;
            end

            tick_d    = wrap && !restart;
            clk_out_d = running_n && (cnt_d < high_a_d);
            en_prev_d = en[i];
        end

        // Channel state registers; reset stops the channel until its first load.
        always_ff @(posedge clk_in) begin
            if (rst) begin
                cnt_q     <= '0;
                div_a_q   <= '0;
                high_a_q  <= '0;
                phase_a_q <= '0;
                div_s_q   <= '0;
                high_s_q  <= '0;
                phase_s_q <= '0;
                pending_q <= 1'b0;
                en_prev_q <= 1'b0;
                clk_out_q <= 1'b0;
                tick_q    <= 1'b0;
            end else begin
                cnt_q     <= cnt_d;
                div_a_q   <= div_a_d;
                high_a_q  <= high_a_d;
                phase_a_q <= phase_a_d;
                div_s_q   <= div_s_d;
                high_s_q  <= high_s_d;
                phase_s_q <= phase_s_d;
                pending_q <= pending_d;
                en_prev_q <= en_prev_d;
                clk_out_q <= clk_out_d;
                tick_q    <= tick_d;
            end
        end

        assign clk_out[i] = clk_out_q;
        assign tick[i]    = tick_q;
        assign pending[i] = pending_q;
    end

endmodule

// File: tb/tb_multi_clk_divider.sv
// Testbench for multi_clk_divider: directed table, hand-written corner
// sequences and randomized traffic, all checked against a behavioural model.
module tb_multi_clk_divider;

    localparam int NCH = 4;
    localparam int W   = 8;

    logic               clk_in = 1'b0;
    logic               rst;
    logic [NCH-1:0]     en;
    logic [NCH*W-1:0]   div;
    logic [NCH*W-1:0]   high;
    logic [NCH*W-1:0]   phase;
    logic [NCH-1:0]     load;
    logic               sync;
    logic [NCH-1:0]     clk_out;
    logic [NCH-1:0]     tick;
    logic [NCH-1:0]     pending;

    multi_clk_divider #(.NCH(NCH), .W(W)) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .en      (en),
        .div     (div),
        .high    (high),
        .phase   (phase),
        .load    (load),
        .sync    (sync),
        .clk_out (clk_out),
        .tick    (tick),
        .pending (pending)
    );

    // Free-running system clock.
    always #5 clk_in = ~clk_in;

    int compared   = 0;
    int mismatched = 0;

    // Behavioural model: position within the period plus active/shadow settings.
    int m_div_a[NCH];
    int m_high_a[NCH];
    int m_phase_a[NCH];
    int m_div_s[NCH];
    int m_high_s[NCH];
    int m_phase_s[NCH];
    int m_pos[NCH];
    bit m_pend[NCH];
    bit m_en_prev[NCH];

    logic [NCH-1:0] exp_clk;
    logic [NCH-1:0] exp_tick;
    logic [NCH-1:0] exp_pend;

    typedef struct {
        logic en0;
        logic load0;
        logic sync;
        int   d;
        int   h;
        int   p;
        logic e_clk;
        logic e_tick;
        logic e_pend;
    } vec_t;

    vec_t tbl[32];

    task automatic model_step();
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                m_div_a[c] = 0;  m_high_a[c] = 0;  m_phase_a[c] = 0;
                m_div_s[c] = 0;  m_high_s[c] = 0;  m_phase_s[c] = 0;
                m_pos[c] = 0;    m_pend[c] = 1'b0; m_en_prev[c] = 1'b0;
            end
            exp_clk  = '0;
            exp_tick = '0;
            exp_pend = '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                int d_in;
                int h_in;
                int p_in;
                int old_div;
                bit run;
                bit period_end;
                bit start;
                d_in       = int'(div[c*W +: W]);
                h_in       = int'(high[c*W +: W]);
                p_in       = int'(phase[c*W +: W]);
                old_div    = m_div_a[c];
                run        = en[c] && (old_div > 0);
                period_end = run && (((m_pos[c] + 1) % old_div) == 0);
                start      = en[c] && (sync || !m_en_prev[c]);
                if (period_end || !run || sync) begin
                    m_div_a[c]   = load[c] ? d_in : m_div_s[c];
                    m_high_a[c]  = load[c] ? h_in : m_high_s[c];
                    m_phase_a[c] = load[c] ? p_in : m_phase_s[c];
                    m_pend[c]    = 1'b0;
                end else if (load[c]) begin
                    m_pend[c] = 1'b1;
                end
                if (load[c]) begin
                    m_div_s[c]   = d_in;
                    m_high_s[c]  = h_in;
                    m_phase_s[c] = p_in;
                end
                if (start)
                    m_pos[c] = (m_phase_a[c] < m_div_a[c]) ? m_phase_a[c] : 0;
                else if (run)
                    m_pos[c] = (m_pos[c] + 1) % old_div;
                else
                    m_pos[c] = 0;
                exp_tick[c]  = period_end && !start;
                exp_clk[c]   = en[c] && (m_div_a[c] > 0) && (m_pos[c] < m_high_a[c]);
                exp_pend[c]  = m_pend[c];
                m_en_prev[c] = en[c];
            end
        end
    endtask

    task automatic check_value(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, expv);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, expv);
        end
    endtask

    task automatic checkOutput(input string name);
        check_value({name, "_clk"},  clk_out, exp_clk);
        check_value({name, "_tick"}, tick,    exp_tick);
        check_value({name, "_pend"}, pending, exp_pend);
    endtask

    task automatic applyStimulus(input string name);
        model_step();
        @(posedge clk_in);
        #1;
        checkOutput(name);
    endtask

    task automatic set_ch(input int ch, input int d, input int h, input int p);
        div[ch*W +: W]   = W'(d);
        high[ch*W +: W]  = W'(h);
        phase[ch*W +: W] = W'(p);
    endtask

    initial begin
        logic [NCH-1:0] t_exp;

        rst = 1'b1; en = '0; load = '0; sync = 1'b0;
        div = '0; high = '0; phase = '0;

        // Channel 0 vectors: basic divide, glitch-free update, load at wrap,
        // load while disabled, enable at phase, sync restart.
        tbl[0]  = '{1, 1, 0, 4, 2, 0, 1, 0, 0};
        tbl[1]  = '{1, 0, 0, 4, 2, 0, 1, 0, 0};
        tbl[2]  = '{1, 0, 0, 4, 2, 0, 0, 0, 0};
        tbl[3]  = '{1, 0, 0, 4, 2, 0, 0, 0, 0};
        tbl[4]  = '{1, 0, 0, 4, 2, 0, 1, 1, 0};
        tbl[5]  = '{1, 0, 0, 4, 2, 0, 1, 0, 0};
        tbl[6]  = '{1, 1, 0, 6, 3, 0, 0, 0, 1};
        tbl[7]  = '{1, 0, 0, 6, 3, 0, 0, 0, 1};
        tbl[8]  = '{1, 0, 0, 6, 3, 0, 1, 1, 0};
        tbl[9]  = '{1, 0, 0, 6, 3, 0, 1, 0, 0};
        tbl[10] = '{1, 0, 0, 6, 3, 0, 1, 0, 0};
        tbl[11] = '{1, 0, 0, 6, 3, 0, 0, 0, 0};
        tbl[12] = '{1, 0, 0, 6, 3, 0, 0, 0, 0};
        tbl[13] = '{1, 0, 0, 6, 3, 0, 0, 0, 0};
        tbl[14] = '{1, 0, 0, 6, 3, 0, 1, 1, 0};
        tbl[15] = '{1, 0, 0, 6, 3, 0, 1, 0, 0};
        tbl[16] = '{1, 0, 0, 6, 3, 0, 1, 0, 0};
        tbl[17] = '{1, 0, 0, 6, 3, 0, 0, 0, 0};
        tbl[18] = '{1, 0, 0, 6, 3, 0, 0, 0, 0};
        tbl[19] = '{1, 0, 0, 6, 3, 0, 0, 0, 0};
        tbl[20] = '{1, 1, 0, 3, 1, 0, 1, 1, 0};
        tbl[21] = '{1, 0, 0, 3, 1, 0, 0, 0, 0};
        tbl[22] = '{1, 0, 0, 3, 1, 0, 0, 0, 0};
        tbl[23] = '{1, 0, 0, 3, 1, 0, 1, 1, 0};
        tbl[24] = '{0, 0, 0, 3, 1, 0, 0, 0, 0};
        tbl[25] = '{0, 1, 0, 5, 5, 3, 0, 0, 0};
        tbl[26] = '{1, 0, 0, 5, 5, 3, 1, 0, 0};
        tbl[27] = '{1, 0, 0, 5, 5, 3, 1, 0, 0};
        tbl[28] = '{1, 0, 0, 5, 5, 3, 1, 1, 0};
        tbl[29] = '{1, 0, 0, 5, 5, 3, 1, 0, 0};
        tbl[30] = '{1, 0, 1, 5, 5, 3, 1, 0, 0};
        tbl[31] = '{1, 0, 0, 5, 5, 3, 1, 0, 0};

        applyStimulus("reset0");
        applyStimulus("reset1");
        check_value("reset_clk",  clk_out, 4'b0000);
        check_value("reset_pend", pending, 4'b0000);
        rst = 1'b0;

        for (int r = 0; r < 32; r++) begin
            en[0]   = tbl[r].en0;
            load[0] = tbl[r].load0;
            sync    = tbl[r].sync;
            set_ch(0, tbl[r].d, tbl[r].h, tbl[r].p);
            applyStimulus($sformatf("tbl%0d", r));
            check_bit($sformatf("tbl%0d_clk0", r),  clk_out[0], tbl[r].e_clk);
            check_bit($sformatf("tbl%0d_tick0", r), tick[0],    tbl[r].e_tick);
            check_bit($sformatf("tbl%0d_pend0", r), pending[0], tbl[r].e_pend);
        end
        en = '0; load = '0; sync = 1'b0;

        // Phase alignment across channels and sync restart.
        rst = 1'b1;
        applyStimulus("ph_rst");
        rst = 1'b0;
        set_ch(0, 4, 2, 0);
        set_ch(1, 4, 2, 2);
        set_ch(2, 4, 2, 5);
        set_ch(3, 0, 0, 0);
        en = 4'b0111; load = 4'b1111;
        applyStimulus("ph_load");
        check_value("ph_load_clk", clk_out, 4'b0101);
        load = '0;
        for (int k = 0; k < 3; k++) applyStimulus("ph_run");
        sync = 1'b1;
        applyStimulus("ph_sync");
        check_value("ph_sync_clk",  clk_out, 4'b0101);
        check_value("ph_sync_tick", tick,    4'b0000);
        sync = 1'b0;
        applyStimulus("ph_s1");
        check_value("ph_s1_clk", clk_out, 4'b0101);
        applyStimulus("ph_s2");
        check_value("ph_s2_clk",  clk_out, 4'b0010);
        check_value("ph_s2_tick", tick,    4'b0010);

        // Load coincident with sync restarts at the new phase.
        set_ch(1, 4, 2, 1);
        load = 4'b0010; sync = 1'b1;
        applyStimulus("ldsync");
        check_value("ldsync_clk",  clk_out, 4'b0111);
        check_value("ldsync_pend", pending, 4'b0000);
        load = '0; sync = 1'b0;

        // Duty boundaries: high=0, high=div, div=1, div=0.
        set_ch(0, 4, 0, 0);
        set_ch(1, 4, 4, 0);
        set_ch(2, 1, 1, 0);
        set_ch(3, 0, 3, 0);
        en = 4'b1111; load = 4'b1111; sync = 1'b1;
        applyStimulus("bnd_load");
        check_value("bnd_load_clk",  clk_out, 4'b0110);
        check_value("bnd_load_tick", tick,    4'b0000);
        load = '0; sync = 1'b0;
        for (int k = 0; k < 8; k++) begin
            applyStimulus($sformatf("bnd%0d", k));
            t_exp = 4'b0100;
            if (k % 4 == 3) t_exp = 4'b0111;
            check_value($sformatf("bnd%0d_clk_h", k),  clk_out, 4'b0110);
            check_value($sformatf("bnd%0d_tick_h", k), tick,    t_exp);
        end

        // Pending shadow, then reset mid-period clears everything.
        set_ch(0, 5, 2, 0);
        load = 4'b0001;
        applyStimulus("pend_set");
        check_value("pend_set_h", pending, 4'b0001);
        load = '0;
        rst = 1'b1;
        applyStimulus("mid_rst");
        check_value("mid_rst_clk",  clk_out, 4'b0000);
        check_value("mid_rst_tick", tick,    4'b0000);
        check_value("mid_rst_pend", pending, 4'b0000);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            applyStimulus("post_rst");
            check_value("post_rst_clk", clk_out, 4'b0000);
        end
        load = 4'b1111;
        applyStimulus("reload");
        check_value("reload_clk", clk_out, 4'b0111);
        load = '0;

        // Randomized traffic checked against the model.
        for (int n = 0; n < 1500; n++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 15) == 0) en[c] = ~en[c];
                load[c] = ($urandom_range(0, 7) == 0);
                set_ch(c, $urandom_range(0, 7), $urandom_range(0, 8), $urandom_range(0, 8));
            end
            sync = ($urandom_range(0, 31) == 0);
            rst  = ($urandom_range(0, 299) == 0);
            applyStimulus("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
